// File: rtl/formula_arg_scheduler.sv
// -----------------------------------------------------------------------------
// formula_arg_scheduler
//
// Queues operand triples (a, b, c) from an upstream valid/ready source and hands
// them one at a time to a downstream formula FSM. Each triple is presented with a
// one-cycle arg_vld pulse. The operands are then held until the formula FSM
// returns res_vld, and only after that is the next triple issued.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   TIMEOUT  WAIT cycles allowed before abort (abort build only)
//
// Build option
//   FORMULA_ARG_SCHED_TIMEOUT_EN  defined: a WAIT that lasts TIMEOUT cycles
//                                 without res_vld aborts to IDLE and sets the
//                                 sticky timeout_err flag.
//                                 undefined: WAIT is held until res_vld and
//                                 timeout_err is tied low.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   in_vld       upstream triple valid
//   in_rdy       scheduler can accept a triple (FIFO not full, out of reset)
//   in_a/b/c     upstream operands, 32 bits each
//   arg_vld      single-cycle issue pulse to the formula FSM
//   a/b/c        operands to the formula FSM, held from ISSUE through WAIT
//   res_vld      completion pulse from the formula FSM
//   busy         state is not IDLE
//   count        triples queued and not yet issued
//   timeout_err  sticky abort flag
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | nothing in flight; leave when the FIFO holds a triple
// ISSUE | arg_vld high for one cycle; the head is popped on exit
// WAIT  | operands held; wait for res_vld (or abort on timeout)
// -----------------------------------------------------------------------------
module formula_arg_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [31:0]                  in_a,
  input  logic [31:0]                  in_b,
  input  logic [31:0]                  in_c,
  output logic                         arg_vld,
  output logic [31:0]                  a,
  output logic [31:0]                  b,
  output logic [31:0]                  c,
  input  logic                         res_vld,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic          push;
  logic          pop;
  logic          load;
  logic          tmo_hit;
  logic [95:0]   head;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  // in_rdy is taken from the registered count and is forced low while reset is
  // asserted, so no push can slip in during reset.
  assign in_rdy = rst && (count_q != CW'(DEPTH));
  assign push   = in_vld && in_rdy;
  assign head   = mem[rd_ptr];
  assign count  = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_a, in_b, in_c};
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional WAIT abort
  // ---------------------------------------------------------------------------
`ifdef FORMULA_ARG_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // tmo_cnt holds the number of WAIT cycles already completed. The abort fires
  // on the edge that would complete the TIMEOUT-th cycle. A res_vld on that
  // same edge takes priority, so the transition is normal.
  assign tmo_hit = (state_q == WAIT) && !res_vld && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q != WAIT) begin
        tmo_cnt <= '0;
      end else if (!res_vld && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = err_q;
`else
  assign tmo_hit     = 1'b0;
  // The abort counter is compiled out, so TIMEOUT has no effect in this build
  // and the flag is always low.
  assign timeout_err = (TIMEOUT < 0);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (res_vld) begin
          state_d = (count_q != '0) ? ISSUE : IDLE;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // load marks every edge that enters ISSUE. ISSUE always goes to WAIT, so
  // ISSUE is never entered from itself.
  always_comb begin
    arg_vld = (state_q == ISSUE);
    busy    = (state_q != IDLE);
    pop     = (state_q == ISSUE);
    load    = (state_d == ISSUE) && (state_q != ISSUE);
  end

  // ---------------------------------------------------------------------------
  // Operand registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a <= '0;
      b <= '0;
      c <= '0;
    end else if (load) begin
      a <= head[95:64];
      b <= head[63:32];
      c <= head[31:0];
    end
  end

endmodule
